// File: rtl/can_pkg.sv
// can_pkg: controller register map, RX FIFO sizing, fetch state encoding and frame-length helper
package can_pkg;
  localparam logic [7:0] REG_CMR   = 8'd1;
  localparam logic [7:0] REG_IR    = 8'd3;
  localparam logic [7:0] REG_RXBUF = 8'd16;
  localparam logic [7:0] CMR_RRB   = 8'h04;
  localparam int FIFO_DEPTH = 64;
  localparam int MAX_FRAME  = 13;
  typedef enum logic [2:0] {S_IDLE, S_GAP, S_RD_IR, S_RD_INFO, S_RD_BYTE, S_WR_REL} state_t;
  function automatic logic [31:0] reg_addr(input logic [7:0] r);
    return {22'd0, r, 2'b00};
  endfunction
  // bytes following the info byte: id bytes (2 SFF / 4 EFF) plus data clamped to 8
  function automatic logic [3:0] data_len(input logic [7:0] info);
    return (info[7] ? 4'd4 : 4'd2) + (info[3:0] > 4'd8 ? 4'd8 : info[3:0]);
  endfunction
endpackage

// File: rtl/can_rx_fetch_if.sv
// can_rx_fetch_if: register bus between fetch engine (master) and access stage (slave); addr/din/wren/rden out, dout/valid back
interface can_rx_fetch_if;
  logic [31:0] addr_32b_o;
  logic [31:0] din_32b_o;
  logic [31:0] dout_32b_i;
  logic        wren_o;
  logic        rden_o;
  logic        dout_32b_valid_i;
  modport master(output addr_32b_o, din_32b_o, wren_o, rden_o, input dout_32b_i, dout_32b_valid_i);
  modport slave(input addr_32b_o, din_32b_o, wren_o, rden_o, output dout_32b_i, dout_32b_valid_i);
endinterface

// File: rtl/can_rx_fifo.sv
// can_rx_fifo: 64x8 sync FIFO; ports clk, rst, push/din, pop/dout, empty, count, mark (save write pointer), restore (rewind to mark)
module can_rx_fifo import can_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       mark,
  input  logic       restore,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic [6:0] count
);
  logic [7:0] mem [FIFO_DEPTH];
  logic [6:0] wptr, rptr, mptr, rptr_n;
  logic wr, rd;
  assign count  = wptr - rptr;
  assign empty  = count == 7'd0;
  assign dout   = mem[rptr[5:0]];
  assign wr     = push && !restore && count != 7'(FIFO_DEPTH);
  assign rd     = pop && !empty;
  assign rptr_n = rptr + 7'(rd);
  always_ff @(posedge clk) if (wr) mem[wptr[5:0]] <= din;
  // if the reader already consumed part of the dropped frame, rewind only to the read pointer
  always_ff @(posedge clk or posedge rst)
    if (rst) {wptr, rptr, mptr} <= '0;
    else begin
      wptr <= restore ? ((7'(mptr - rptr_n) <= 7'(wptr - rptr_n)) ? mptr : rptr_n) : wptr + 7'(wr);
      rptr <= rptr_n;
      mptr <= mark ? wptr : mptr;
    end
endmodule

// File: rtl/can_rx_fetch.sv
// can_rx_fetch: polls CAN IR on interrupt, reads info+frame bytes into RX FIFO, releases buffer.
// Ports: clk, rst (async high), en_i, can_int_n_i, bus (can_rx_fetch_if.master), rx_rden_i, rx_data_o,
// rx_empty_o, rx_count_o, frame_done_o, err_o. Macro CAN_RX_TIMEOUT_EN enables the access timeout.
module can_rx_fetch import can_pkg::*; #(
  parameter int IDLE_GAP    = 10,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       can_int_n_i,
  can_rx_fetch_if.master bus,
  input  logic       rx_rden_i,
  output logic [7:0] rx_data_o,
  output logic       rx_empty_o,
  output logic [6:0] rx_count_o,
  output logic       frame_done_o,
  output logic       err_o
);
  state_t state, nxt;
  logic [1:0] int_sync;
  logic [15:0] gap_cnt;
  logic [7:0] reg_idx, last_reg, push_data;
  logic push, mark, restore, waiting, done, space_ok, unused;
  if (TIMEOUT_CYC < 1 || IDLE_GAP < 0) begin : g_cfg_check
    $error("can_rx_fetch: bad timing parameters");
  end
  assign unused   = ^bus.dout_32b_i[31:8];
  assign waiting  = state inside {S_RD_IR, S_RD_INFO, S_RD_BYTE, S_WR_REL};
  // valid during the request pulse cannot belong to this access
  assign done     = waiting && bus.dout_32b_valid_i && !bus.rden_o && !bus.wren_o;
  assign space_ok = rx_count_o <= 7'(FIFO_DEPTH - MAX_FRAME);
`ifdef CAN_RX_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic expired;
  assign expired = waiting && !done && to_cnt == 16'(TIMEOUT_CYC - 1);
`else
  assign err_o   = 1'b0;
  assign restore = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      nxt <= S_IDLE;
      int_sync <= 2'b11;
      gap_cnt <= '0;
      reg_idx <= '0;
      last_reg <= '0;
      push <= 1'b0;
      push_data <= '0;
      mark <= 1'b0;
      frame_done_o <= 1'b0;
      bus.addr_32b_o <= '0;
      bus.din_32b_o <= '0;
      bus.rden_o <= 1'b0;
      bus.wren_o <= 1'b0;
`ifdef CAN_RX_TIMEOUT_EN
      to_cnt <= '0;
      err_o <= 1'b0;
      restore <= 1'b0;
`endif
    end else begin
      int_sync <= {int_sync[0], can_int_n_i};
      bus.rden_o <= 1'b0;
      bus.wren_o <= 1'b0;
      push <= 1'b0;
      mark <= 1'b0;
      frame_done_o <= 1'b0;
`ifdef CAN_RX_TIMEOUT_EN
      to_cnt <= waiting && !done ? to_cnt + 16'd1 : 16'd0;
      restore <= 1'b0;
`endif
      case (state)
        S_IDLE: if (en_i && !int_sync[1]) begin
          state <= S_RD_IR;
          bus.rden_o <= 1'b1;
          bus.addr_32b_o <= reg_addr(REG_IR);
        end
        // a pending frame waits here, without requests, until the FIFO can hold a maximal frame
        S_GAP: if (gap_cnt != 16'd0) gap_cnt <= gap_cnt - 16'd1;
          else if (nxt == S_RD_IR && !en_i) state <= S_IDLE;
          else if (nxt != S_RD_INFO || space_ok) begin
            state <= nxt;
            bus.rden_o <= nxt inside {S_RD_IR, S_RD_INFO, S_RD_BYTE};
            bus.wren_o <= nxt == S_WR_REL;
            mark <= nxt == S_RD_INFO;
            bus.addr_32b_o <= reg_addr(nxt == S_RD_IR ? REG_IR : nxt == S_RD_INFO ? REG_RXBUF :
                                       nxt == S_RD_BYTE ? reg_idx : nxt == S_WR_REL ? REG_CMR : 8'd0);
            bus.din_32b_o <= {24'd0, nxt == S_WR_REL ? CMR_RRB : 8'd0};
          end
        default: if (done) begin
          state <= S_GAP;
          gap_cnt <= 16'(IDLE_GAP);
          push <= state inside {S_RD_INFO, S_RD_BYTE};
          push_data <= bus.dout_32b_i[7:0];
          frame_done_o <= state == S_WR_REL;
          reg_idx <= state == S_RD_INFO ? REG_RXBUF + 8'd1 : reg_idx + 8'd1;
          if (state == S_RD_INFO) last_reg <= REG_RXBUF + {4'd0, data_len(bus.dout_32b_i[7:0])};
          nxt <= state == S_RD_IR ? (bus.dout_32b_i[0] ? S_RD_INFO : S_IDLE) :
                 state == S_RD_INFO ? S_RD_BYTE :
                 state == S_RD_BYTE ? (reg_idx == last_reg ? S_WR_REL : S_RD_BYTE) : S_RD_IR;
        end
`ifdef CAN_RX_TIMEOUT_EN
        else if (expired) begin
          err_o <= 1'b1;
          restore <= state inside {S_RD_INFO, S_RD_BYTE};
          state <= S_GAP;
          gap_cnt <= 16'(IDLE_GAP);
          nxt <= S_IDLE;
        end
`endif
      endcase
    end
  can_rx_fifo u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(rx_rden_i), .mark(mark), .restore(restore),
    .din(push_data), .dout(rx_data_o), .empty(rx_empty_o), .count(rx_count_o)
  );
endmodule

// File: tb/tb_can_rx_fetch.sv
// tb_can_rx_fetch: table-driven and random frame fetches against a register-file bus model and byte queue
module tb_can_rx_fetch;
  localparam int GAP = 10;
  typedef struct {logic [7:0] info; int stored;} vec_t;
  logic clk = 0, rst = 1, en = 0, rx_rden = 0;
  logic int_n, rx_empty, frame_done, err;
  logic [7:0] rx_data;
  logic [6:0] rx_count;
  can_rx_fetch_if bus();
  can_rx_fetch #(.IDLE_GAP(GAP), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst(rst), .en_i(en), .can_int_n_i(int_n), .bus(bus), .rx_rden_i(rx_rden),
    .rx_data_o(rx_data), .rx_empty_o(rx_empty), .rx_count_o(rx_count),
    .frame_done_o(frame_done), .err_o(err)
  );
  always #5 clk = ~clk;
  logic [7:0] regs [256];
  logic [7:0] exp_q [$];
  vec_t tbl [5];
  int checks = 0, errors = 0;
  int posted = 0, rel_cnt = 0, fd_cnt = 0, cyc = 0, last_valid = -1000;
  int rd16_cnt = 0, rd_cnt = 0, wr_cnt = 0, last_rd = 0;
  int gap_viol = 0, busy_viol = 0, both_viol = 0, fmt_viol = 0, seq_viol = 0;
  int withhold = 0, hold_cyc = 0, lat = 0;
  logic busy = 0, cur_wr = 0;
  logic [7:0] cur, cur_din;
  assign int_n = !(posted > rel_cnt);
  // access stage: one access at a time, 1..4 cycle latency, register file reads, release write clears IR
  always @(negedge clk) begin
    cyc++;
    bus.dout_32b_valid_i = 1'b0;
    if (frame_done) fd_cnt++;
    if (rst) busy = 1'b0;
    else if (bus.rden_o || bus.wren_o) begin
      if (bus.rden_o && bus.wren_o) both_viol++;
      if (busy) busy_viol++;
      if (cyc - last_valid < GAP) gap_viol++;
      if (bus.addr_32b_o[31:10] != 0 || bus.addr_32b_o[1:0] != 0 || bus.din_32b_o[31:8] != 0) fmt_viol++;
      cur = bus.addr_32b_o[9:2];
      cur_wr = bus.wren_o;
      cur_din = bus.din_32b_o[7:0];
      if (cur_wr && (cur != 8'd1 || cur_din != 8'h04)) fmt_viol++;
      busy = 1'b1;
      lat = $urandom_range(1, 4);
      hold_cyc = cyc;
      if (bus.rden_o && cur >= 8'd16) begin
        if (cur > 8'd16 && int'(cur) != last_rd + 1) seq_viol++;
        if (cur == 8'd16) rd16_cnt++;
        last_rd = int'(cur);
      end
      if (bus.rden_o) rd_cnt++; else wr_cnt++;
    end else if (busy && !(withhold != 0 && int'(cur) >= withhold && !cur_wr)) begin
      lat--;
      if (lat == 0) begin
        busy = 1'b0;
        last_valid = cyc;
        bus.dout_32b_valid_i = 1'b1;
        bus.dout_32b_i = {24'($urandom), cur == 8'd3 ? {7'd0, posted > rel_cnt} : regs[cur]};
        if (cur_wr && cur == 8'd1 && cur_din == 8'h04) rel_cnt++;
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int model_len(input logic [7:0] info);
    int n = int'(info[3:0]);
    if (n > 8) n = 8;
    return (info[7] ? 4 : 2) + n;
  endfunction
  task automatic post(input logic [7:0] info);
    regs[16] = info;
    for (int i = 17; i <= 28; i++) regs[i] = 8'($urandom);
    exp_q.push_back(info);
    for (int i = 0; i < model_len(info); i++) exp_q.push_back(regs[17 + i]);
    posted++;
  endtask
  task automatic finish(input string tag, input int exp_cnt, input int exp_last);
    int fd0 = fd_cnt;
    int rel0 = rel_cnt;
    int n = 0;
    while (fd_cnt == fd0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (50) @(negedge clk);
    chk({tag, " frame_done"}, fd_cnt - fd0, 1);
    chk({tag, " release"}, rel_cnt - rel0, 1);
    chk({tag, " count"}, int'(rx_count), exp_cnt);
    chk({tag, " last_reg"}, last_rd, exp_last);
  endtask
  task automatic pop_n(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      int e;
      if (exp_q.size() > 0) e = int'(exp_q.pop_front()); else e = -1;
      chk({tag, " byte"}, int'(rx_data), e);
      rx_rden = 1'b1;
      @(negedge clk);
    end
    rx_rden = 1'b0;
  endtask
  task automatic pop_all(input string tag);
    pop_n(int'(rx_count), tag);
    @(negedge clk);
    chk({tag, " empty"}, int'(rx_empty), 1);
    chk({tag, " model drained"}, exp_q.size(), 0);
  endtask
  initial begin
    int r0, n, st, rel0, wr0;
    logic [7:0] info;
    for (int i = 0; i < 256; i++) regs[i] = 8'd0;
    tbl[0] = '{8'h8F, 13};
    tbl[1] = '{8'h00, 3};
    tbl[2] = '{8'h83, 8};
    tbl[3] = '{8'h0A, 11};
    tbl[4] = '{8'h85, 10};
    repeat (3) @(negedge clk);
    chk("rst empty", int'(rx_empty), 1);
    chk("rst count", int'(rx_count), 0);
    chk("rst rden", int'(bus.rden_o), 0);
    chk("rst wren", int'(bus.wren_o), 0);
    chk("rst addr", int'(bus.addr_32b_o), 0);
    chk("rst frame_done", int'(frame_done), 0);
    chk("rst err", int'(err), 0);
    rst = 0;
    @(negedge clk);
    post(8'h08);
    repeat (60) @(negedge clk);
    chk("en gate reads", rd_cnt, 0);
    en = 1;
    finish("sff8", 11, 26);
    pop_all("sff8");
    for (int i = 0; i < 5; i++) begin
      post(tbl[i].info);
      finish($sformatf("tbl%0d", i), tbl[i].stored, 15 + tbl[i].stored);
      pop_all($sformatf("tbl%0d", i));
    end
    repeat (6) begin
      info = 8'($urandom);
      st = 1 + model_len(info);
      post(info);
      finish($sformatf("rnd %02h", info), st, 15 + st);
      pop_all("rnd");
    end
    for (int i = 0; i < 5; i++) begin
      post(8'h08);
      finish("fill", 11 * (i + 1), 26);
    end
    post(8'h08);
    r0 = rd16_cnt;
    repeat (100) @(negedge clk);
    chk("bp held at 55", rd16_cnt - r0, 0);
    chk("bp count 55", int'(rx_count), 55);
    pop_n(3, "bp");
    repeat (60) @(negedge clk);
    chk("bp held at 52", rd16_cnt - r0, 0);
    pop_n(1, "bp");
    finish("bp", 62, 26);
    chk("bp info reads", rd16_cnt - r0, 1);
    pop_all("bp");
    post(8'h8F);
    r0 = rd16_cnt;
    n = 0;
    while (!(rd16_cnt > r0 && last_rd >= 19) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid reached", int'(n < 3000), 1);
    rst = 1;
    posted = rel_cnt;
    exp_q.delete();
    rel0 = rel_cnt;
    wr0 = wr_cnt;
    #1;
    chk("rst_mid rden", int'(bus.rden_o), 0);
    chk("rst_mid wren", int'(bus.wren_o), 0);
    chk("rst_mid addr", int'(bus.addr_32b_o), 0);
    chk("rst_mid din", int'(bus.din_32b_o), 0);
    chk("rst_mid empty", int'(rx_empty), 1);
    chk("rst_mid count", int'(rx_count), 0);
    chk("rst_mid frame_done", int'(frame_done), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (100) @(negedge clk);
    chk("rst_mid no release", rel_cnt - rel0, 0);
    chk("rst_mid no write", wr_cnt - wr0, 0);
    chk("rst_mid count after", int'(rx_count), 0);
`ifdef CAN_RX_TIMEOUT_EN
    withhold = 21;
    post(8'h08);
    n = 0;
    while (!err && n < 1500) begin
      @(negedge clk);
      n++;
    end
    chk("to err", int'(err), 1);
    chk("to latency", int'(cyc - hold_cyc >= 250 && cyc - hold_cyc <= 262), 1);
    en = 0;
    exp_q.delete();
    repeat (30) @(negedge clk);
    chk("to count restored", int'(rx_count), 0);
    chk("to err sticky", int'(err), 1);
`endif
    chk("gap violations", gap_viol, 0);
    chk("busy violations", busy_viol, 0);
    chk("rd+wr violations", both_viol, 0);
    chk("format violations", fmt_viol, 0);
    chk("order violations", seq_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
